// File: rtl/hood_display_arbiter.sv
// ============================================================================
//  Module   : hood_display_arbiter
//  Purpose  : Shares the hood's 8-digit time display between current time,
//             extraction countdown and alarm, with priority, hold and blink.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hood_display_arbiter #(
    parameter int unsigned HOLD_CYCLES  = 200_000_000,
    parameter int unsigned BLINK_CYCLES = 50_000_000,
    parameter logic [3:0]  BLANK_CODE   = 4'hE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic [2:0]  grant,
    output logic [31:0] time_data,
    output logic        switch_pulse,
    output logic        blink_phase
);

    localparam int HOLD_W  = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [HOLD_W-1:0]  c_hold_load = HOLD_W'(HOLD_CYCLES);
    localparam logic [BLINK_W-1:0] c_blink_last = BLINK_W'(BLINK_CYCLES - 1);

    // One-hot owner encoding doubles as the registered grant output
    localparam logic [2:0] ST_OWN0 = 3'b001;
    localparam logic [2:0] ST_OWN1 = 3'b010;
    localparam logic [2:0] ST_OWN2 = 3'b100;

    logic [2:0]         r_state;
    logic [HOLD_W-1:0]  r_hold;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [31:0]        r_raw;
    logic [31:0]        r_time_data;
    logic               r_switch;

    logic [2:0]         w_state_next;
    logic [HOLD_W-1:0]  w_hold_next;
    logic [BLINK_W-1:0] w_blink_cnt_next;
    logic               w_blink_phase_next;
    logic [31:0]        w_raw_next;
    logic [31:0]        w_time_next;
    logic               w_switch;
    logic               w_expired;

    // The current-time source is always considered requesting
    logic w_unused_req0;
    assign w_unused_req0 = req[0];

    assign w_expired = (r_hold == '0);

    always_comb begin
        w_state_next       = r_state;
        w_hold_next        = r_hold;
        w_blink_cnt_next   = r_blink_cnt;
        w_blink_phase_next = r_blink_phase;
        w_raw_next         = r_raw;
        w_time_next        = r_time_data;

        case (r_state)
            ST_OWN0: begin
                if (req[2])      w_state_next = ST_OWN2;
                else if (req[1]) w_state_next = ST_OWN1;
            end
            ST_OWN1: begin
                if (req[2])                   w_state_next = ST_OWN2;
                else if (!req[1] && w_expired) w_state_next = ST_OWN0;
            end
            ST_OWN2: begin
                if (!req[2] && w_expired)
                    w_state_next = req[1] ? ST_OWN1 : ST_OWN0;
            end
            default: w_state_next = ST_OWN0;
        endcase

        w_switch = (w_state_next != r_state);

        if (w_switch && (w_state_next != ST_OWN0))
            w_hold_next = c_hold_load;
        else if (!w_expired)
            w_hold_next = r_hold - HOLD_W'(1);

        if ((w_state_next != ST_OWN2) || w_switch) begin
            w_blink_cnt_next   = '0;
            w_blink_phase_next = 1'b0;
        end else if (r_blink_cnt == c_blink_last) begin
            w_blink_cnt_next   = '0;
            w_blink_phase_next = ~r_blink_phase;
        end else begin
            w_blink_cnt_next   = r_blink_cnt + BLINK_W'(1);
        end

        // A non-default owner that has dropped its request keeps its last word
        case (w_state_next)
            ST_OWN1: if (w_switch || req[1]) w_raw_next = data1;
            ST_OWN2: if (w_switch || req[2]) w_raw_next = data2;
            default: w_raw_next = data0;
        endcase

        if (w_blink_phase_next)
            w_time_next = {BLANK_CODE, BLANK_CODE, w_raw_next[23:20],
                           BLANK_CODE, BLANK_CODE, w_raw_next[11:8],
                           BLANK_CODE, BLANK_CODE};
        else
            w_time_next = w_raw_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_OWN0;
            r_hold        <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_raw         <= '0;
            r_time_data   <= '0;
            r_switch      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_hold        <= w_hold_next;
            r_blink_cnt   <= w_blink_cnt_next;
            r_blink_phase <= w_blink_phase_next;
            r_raw         <= w_raw_next;
            r_time_data   <= w_time_next;
            r_switch      <= w_switch;
        end
    end

    assign grant        = r_state;
    assign time_data    = r_time_data;
    assign switch_pulse = r_switch;
    assign blink_phase  = r_blink_phase;

endmodule

`default_nettype wire

// File: tb/tb_hood_display_arbiter.sv
// ============================================================================
//  Module   : tb_hood_display_arbiter
//  Purpose  : Self-checking bench: directed vector table, hand sequences and
//             randomized traffic against a cycle-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hood_display_arbiter;

    localparam int HOLD  = 10;
    localparam int BLINK = 4;

    localparam logic [31:0] D0 = 32'h12F3_4F56;
    localparam logic [31:0] D1 = 32'h00F0_1F30;
    localparam logic [31:0] D2 = 32'h07F3_0F00;
    localparam logic [31:0] BL = 32'hEEFE_EFEE;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [31:0] data0, data1, data2;
    logic [2:0]  grant;
    logic [31:0] time_data;
    logic        switch_pulse;
    logic        blink_phase;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_owner = 0;
    int          m_hold  = 0;
    int          m_age   = 0;
    logic [31:0] m_word  = '0;
    logic [2:0]  e_grant = 3'b001;
    logic [31:0] e_time  = '0;
    logic        e_sw    = 1'b0;
    logic        e_ph    = 1'b0;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [31:0] d1;
        int          n;
        logic [2:0]  g;
        logic [31:0] t;
        logic        sw;
        logic        ph;
    } vec_t;

    vec_t tbl[$];

    hood_display_arbiter #(
        .HOLD_CYCLES (HOLD),
        .BLINK_CYCLES(BLINK),
        .BLANK_CODE  (4'hE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .data0       (data0),
        .data1       (data1),
        .data2       (data2),
        .grant       (grant),
        .time_data   (time_data),
        .switch_pulse(switch_pulse),
        .blink_phase (blink_phase)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] blank_word(input logic [31:0] w);
        logic [31:0] o;
        o = w;
        for (int i = 0; i < 8; i++)
            if (i != 2 && i != 5) o[i*4 +: 4] = 4'hE;
        return o;
    endfunction

    // Owner = highest requester if above current owner; otherwise release
    // to the highest requester once the owner is idle and its hold is spent.
    task automatic model_step();
        int         hi;
        int         nxt;
        logic [2:0] r;
        bit         sw;
        if (rst) begin
            m_owner = 0; m_hold = 0; m_age = 0; m_word = '0;
            e_grant = 3'b001; e_time = '0; e_sw = 1'b0; e_ph = 1'b0;
            return;
        end
        r   = {req[2:1], 1'b1};
        hi  = r[2] ? 2 : (r[1] ? 1 : 0);
        nxt = m_owner;
        if (hi > m_owner)
            nxt = hi;
        else if (!r[m_owner] && m_hold == 0)
            nxt = hi;
        sw = (nxt != m_owner);
        if (sw && nxt != 0) m_hold = HOLD;
        else if (m_hold > 0) m_hold--;
        m_age = (nxt == 2 && !sw) ? m_age + 1 : 0;
        if (sw || r[nxt])
            m_word = (nxt == 0) ? data0 : ((nxt == 1) ? data1 : data2);
        m_owner = nxt;
        e_ph    = (nxt == 2) && (((m_age / BLINK) % 2) == 1);
        e_time  = e_ph ? blank_word(m_word) : m_word;
        e_sw    = sw;
        e_grant = 3'b001 << nxt;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] g, input logic [31:0] t,
                             input logic sw, input logic ph);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".time"},  time_data, t);
        chk({tag, ".sw"},    32'(switch_pulse), 32'(sw));
        chk({tag, ".blink"}, 32'(blink_phase), 32'(ph));
    endtask

    function automatic void add(input logic r, input logic [2:0] q, input logic [31:0] d1,
                                input int n, input logic [2:0] g, input logic [31:0] t,
                                input logic sw, input logic ph);
        vec_t v;
        v.rst = r; v.req = q; v.d1 = d1; v.n = n;
        v.g = g; v.t = t; v.sw = sw; v.ph = ph;
        tbl.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = 3'b000; data0 = D0; data1 = D1; data2 = D2;

        // reset, short req1 with frozen data, simultaneous rise, blink, 2->1 handoff
        add(1, 3'b000, D1,            3, 3'b001, 32'h0, 0, 0);
        add(0, 3'b000, D1,            2, 3'b001, D0,    0, 0);
        add(0, 3'b010, D1,            1, 3'b010, D1,    1, 0);
        add(0, 3'b000, 32'h99F99F99, 10, 3'b010, D1,    0, 0);
        add(0, 3'b000, D1,            1, 3'b001, D0,    1, 0);
        add(0, 3'b000, D1,            1, 3'b001, D0,    0, 0);
        add(0, 3'b110, D1,            1, 3'b100, D2,    1, 0);
        add(0, 3'b110, D1,            3, 3'b100, D2,    0, 0);
        add(0, 3'b110, D1,            4, 3'b100, BL,    0, 1);
        add(0, 3'b110, D1,            4, 3'b100, D2,    0, 0);
        add(0, 3'b010, D1,            1, 3'b010, D1,    1, 0);
        add(0, 3'b010, D1,            2, 3'b010, D1,    0, 0);
        add(0, 3'b000, D1,            8, 3'b010, D1,    0, 0);
        add(0, 3'b000, D1,            1, 3'b001, D0,    1, 0);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                rst = tbl[i].rst; req = tbl[i].req; data1 = tbl[i].d1;
                step();
                check_all($sformatf("vec%0d.%0d", i, k), tbl[i].g, tbl[i].t, tbl[i].sw, tbl[i].ph);
            end
        end

        // Preemption mid-hold, then 2->1 handoff with hold reload
        data1 = D1;
        req = 3'b010; step(); check_all("pre.enter1", 3'b010, D1, 1, 0);
        for (int k = 0; k < 2; k++) begin step(); chk("pre.hold1", 32'(grant), 32'(3'b010)); end
        req = 3'b110; step(); check_all("pre.preempt", 3'b100, D2, 1, 0);
        for (int k = 0; k < 11; k++) begin step(); chk("pre.own2", 32'(grant), 32'(3'b100)); end
        req = 3'b010; step(); check_all("pre.handoff", 3'b010, D1, 1, 0);
        req = 3'b000;
        for (int k = 0; k < 10; k++) begin step(); chk("pre.reload", 32'(grant), 32'(3'b010)); end
        step(); check_all("pre.release", 3'b001, D0, 1, 0);

        // Reset in the blanked half of an alarm hold
        req = 3'b100; step(); chk("rmo.enter", 32'(grant), 32'(3'b100));
        for (int k = 0; k < 4; k++) step();
        check_all("rmo.blanked", 3'b100, BL, 0, 1);
        rst = 1'b1; step(); check_all("rmo.reset", 3'b001, 32'h0, 0, 0);
        rst = 1'b0; req = 3'b000; step(); check_all("rmo.after", 3'b001, D0, 0, 0);
        req = 3'b100; step(); check_all("rmo.reenter", 3'b100, D2, 1, 0);
        req = 3'b000;
        for (int k = 1; k <= 10; k++) begin
            logic ph;
            ph = ((k / BLINK) % 2) == 1;
            step();
            check_all($sformatf("rmo.hold%0d", k), 3'b100, ph ? BL : D2, 0, ph);
        end
        step(); check_all("rmo.release", 3'b001, D0, 1, 0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 3) == 0) data0 = $urandom;
            if ($urandom_range(0, 3) == 0) data1 = $urandom;
            if ($urandom_range(0, 3) == 0) data2 = $urandom;
            step();
            check_all($sformatf("rnd%0d", c), e_grant, e_time, e_sw, e_ph);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hood_display_arbiter.md
# hood_display_arbiter

Time-of-day display arbiter for the kitchen-hood front panel. It shares the single 8-digit time-display driver between three requesters: the current-time counter (default owner), the extraction countdown, and the alarm/reminder source. It applies fixed priority, a minimum-hold window against flicker, and alarm blinking. It sits between the time datapaths and the display driver and supplies that driver's 32-bit packed digit word.

## Interface
- HOLD_CYCLES, 200_000_000, minimum cycles a granted non-default source keeps the display (2 s at 100 MHz); 0 = no hold
- BLINK_CYCLES, 50_000_000, half-period of alarm blink, in cycles; must be ≥1
- BLANK_CODE, 4'hE, nibble value the display driver renders as an unlit digit
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  3  level requests; bit0 current time (always treated as 1), bit1 countdown, bit2 alarm
- data0  in  32  packed word from current time: {hr10, hr1, F, min10, min1, F, sec10, sec1}, 4 bits each
- data1  in  32  packed word from countdown, same format
- data2  in  32  packed word from alarm, same format
- grant  out  3  one-hot current owner
- time_data  out  32  word to the display driver
- switch_pulse  out  1  one-cycle pulse on the cycle grant changes
- blink_phase  out  1  1 while alarm digits are blanked

## Operation
- Owner states: OWN0, OWN1, OWN2. Priority is 2 > 1 > 0.
- Preemption: if a source of higher priority than the owner has req=1, grant moves to it at the next edge, regardless of hold.
- Release: the owner k≠0 releases only when req[k]=0 and hold_cnt has expired. On release, grant goes to the highest remaining requester (falls to 0 if none).
- Hold counter:
  - Loads HOLD_CYCLES on every grant change into OWN1/OWN2.
  - Decrements by 1 per cycle to 0 and saturates there.
  - Expired means hold_cnt==0.
  - Width is $clog2(HOLD_CYCLES+1), minimum 1 bit.
- Data path:
  - While req[owner]=1, time_data <= data_owner each cycle.
  - If the owner drops req during its hold, time_data freezes at the last captured word until release.
  - OWN0 always tracks data0.
- Blink (OWN2 only):
  - blink_cnt counts 0..BLINK_CYCLES-1; blink_phase toggles on wrap.
  - While blink_phase=1, digit nibbles [31:28], [27:24], [19:16], [15:12], [7:4], [3:0] output BLANK_CODE.
  - Separator nibbles [23:20] and [11:8] pass unchanged.
  - Entering OWN2 clears blink_cnt and blink_phase, so the first half-period is lit.
  - Leaving OWN2 forces blink_phase=0.
- Simultaneous events:
  - req1 and req2 rising in the same cycle: grant goes to 2.
  - req2 falling with req1=1 after hold expiry: direct 2→1 handoff. Hold reloads; switch_pulse=1 for one cycle.
  - Preemption and hold expiry in the same cycle: preemption wins.
- Reset (any time, including mid-hold or mid-blink):
  - grant=3'b001, time_data=32'h0, switch_pulse=0, blink_phase=0.
  - hold_cnt=0, blink_cnt=0.

## Timing
- All outputs are registered.
- Latency is 1 cycle from a req edge to grant/time_data/switch_pulse.
- grant and time_data change on the same edge; time_data then reflects the new owner's data sampled at that edge.
- switch_pulse is high exactly in the first cycle of the new grant value.
- With req1 pulsed for 1 cycle, OWN1 lasts HOLD_CYCLES+1 cycles: 1 entry cycle plus HOLD_CYCLES countdown, then release at the next edge.
- After rst deasserts: first edge gives grant=001 and time_data=data0.
- No combinational paths from inputs to outputs.

## Test plan
- Reset/default (HOLD_CYCLES=10, BLINK_CYCLES=4): assert rst 3 cycles with data0=32'h12F3_4F56, then release → grant=001, time_data=0 during rst; time_data=32'h12F34F56 one cycle after release; switch_pulse never set.
- Hold on short request: req1 pulsed 1 cycle with data1=32'h00F0_1F30 → grant=010 next cycle, switch_pulse=1 for 1 cycle, time_data frozen at 32'h00F01F30 for 11 cycles, then grant=001 with switch_pulse pulse.
- Preemption mid-hold: req1=1, then 3 cycles later req2=1 → grant=100 on next edge despite hold; req1 still high when req2 drops after hold → grant=010, hold reloads to 10.
- Simultaneous rise: req1 and req2 both rise same cycle → grant=100; grant never passes through 010.
- Blink pattern: OWN2 with data2=32'h07F3_0F00 → lit for 4 cycles, then time_data=32'hEEFE_EFEE and blink_phase=1 for 4 cycles, repeating; blink_phase=0 immediately after leaving OWN2.
- Reset mid-operation: rst during OWN2, blink_phase=1, hold_cnt=6 → next edge grant=001, blink_phase=0, time_data=0; after release, a new req2 gets a fresh full hold and starts in the lit phase.
